// File: rtl/stopwatch_control_pkg.sv
// Shared types and constants for the stopwatch run/lap controller.
// State encoding is fixed so debug probes read the same everywhere.
package stopwatch_control_pkg;

  localparam int BCD_DIGIT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

endpackage

// File: rtl/stopwatch_control_button.sv
// Button synchroniser plus rising-edge detector.
// Flops reset high so a button held through reset never yields a press.
module button_edge_detector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic press_q, press_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d  = sync_q[SYNC_STAGES-1];
    // registered so the FSM sees a clean one-cycle pulse
    press_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_control.sv
// Run/pause/lap/clear controller ahead of the stopwatch counter chain.
// Gates the 1 Hz tick, issues counter clears and freezes lap values.
module stopwatch_control
  import stopwatch_control_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS = 4,
  parameter int SYNC_STAGES      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_lap_reset,
  input  logic tick,
  input  logic [BCD_DIGIT_WIDTH*NUMBER_OF_DIGITS-1:0] live_number,
  output logic count_en,
  output logic count_clr,
  output logic [BCD_DIGIT_WIDTH*NUMBER_OF_DIGITS-1:0] display_number,
  output logic running,
  output logic lap_active
);

  localparam int W = BCD_DIGIT_WIDTH * NUMBER_OF_DIGITS;

  logic ss_press, lr_press, lap_req;

  state_e state_q, state_d;
  logic [W-1:0] lap_q, lap_d;
  logic clr_q, clr_d;
  logic running_q, running_d;
  logic lap_act_q, lap_act_d;

  button_edge_detector #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (btn_start_stop),
    .press (ss_press)
  );

  button_edge_detector #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lr (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (btn_lap_reset),
    .press (lr_press)
  );

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    // start/stop wins; a simultaneous lap press is dropped
    lap_req = lr_press & ~ss_press;
    unique case (state_q)
      ST_IDLE, ST_PAUSE: begin
        unique case (1'b1)
          ss_press: state_d = ST_RUN;
          lap_req: begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_RUN: begin
        unique case (1'b1)
          ss_press: state_d = ST_PAUSE;
          lap_req: begin
            state_d = ST_LAP;
            lap_d   = live_number;
          end
          default: ;
        endcase
      end
      ST_LAP: begin
        unique case (1'b1)
          ss_press: state_d = ST_PAUSE;
          lap_req:  state_d = ST_RUN;
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_d) lap_d = '0;
    running_d = (state_d == ST_RUN) |
                (state_d == ST_LAP);
    lap_act_d = (state_d == ST_LAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lap_q     <= '0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
      lap_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_q     <= lap_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      lap_act_q <= lap_act_d;
    end
  end

  assign count_en = tick & ((state_q == ST_RUN) |
                            (state_q == ST_LAP));
  assign count_clr      = clr_q;
  assign running        = running_q;
  assign lap_active     = lap_act_q;
  assign display_number = lap_act_q ? lap_q : live_number;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control.
// Scenario tasks check outputs #1 after the rising edge.
module tb_stopwatch_control;
  import stopwatch_control_pkg::*;

  logic clk;
  logic rst_n;
  logic btn_start_stop;
  logic btn_lap_reset;
  logic tick;
  logic [15:0] live_number;
  logic count_en;
  logic count_clr;
  logic [15:0] display_number;
  logic running;
  logic lap_active;

  int errors = 0;
  int checks = 0;

  stopwatch_control #(
    .NUMBER_OF_DIGITS(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_lap_reset  (btn_lap_reset),
    .tick           (tick),
    .live_number    (live_number),
    .count_en       (count_en),
    .count_clr      (count_clr),
    .display_number (display_number),
    .running        (running),
    .lap_active     (lap_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_ss();
    btn_start_stop = 1'b1;
    step(4);
    btn_start_stop = 1'b0;
    step(4);
  endtask

  task automatic press_lap();
    btn_lap_reset = 1'b1;
    step(4);
    btn_lap_reset = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_start_stop = 1'b0;
    btn_lap_reset = 1'b0;
    tick = 1'b0;
    live_number = 16'h0000;
    step(2);
    rst_n = 1'b1;
    live_number = 16'h0031;
    #1;
    checks++;
    if (running !== 1'b0 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags run=%b lap=%b exp 0/0",
               running, lap_active);
    end
    checks++;
    if (count_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_clr got=%b exp=0", count_clr);
    end
    checks++;
    if (display_number !== 16'h0031) begin
      errors++;
      $display("FAIL reset_disp got=%h exp=0031",
               display_number);
    end
    step(4);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      #1;
      checks++;
      if (count_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_tick%0d got=%b exp=0", i, count_en);
      end
      step(1);
      tick = 1'b0;
      checks++;
      if (count_clr !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL idle_state%0d clr=%b run=%b exp 0/0",
                 i, count_clr, running);
      end
      step(1);
    end
  endtask

  task automatic test_start();
    live_number = 16'h0000;
    btn_start_stop = 1'b1;
    step(3);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL start_early got=%b exp=0", running);
    end
    step(1);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL start_k3 got=%b exp=1", running);
    end
    btn_start_stop = 1'b0;
    step(4);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      #1;
      checks++;
      if (count_en !== 1'b1) begin
        errors++;
        $display("FAIL run_tick%0d got=%b exp=1", i, count_en);
      end
      step(1);
      tick = 1'b0;
      #1;
      checks++;
      if (count_en !== 1'b0) begin
        errors++;
        $display("FAIL run_notick%0d got=%b exp=0", i, count_en);
      end
      step(1);
    end
  endtask

  task automatic test_lap();
    live_number = 16'h0123;
    press_lap();
    checks++;
    if (lap_active !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter lap=%b run=%b exp 1/1",
               lap_active, running);
    end
    live_number = 16'h0124;
    tick = 1'b1;
    #1;
    checks++;
    if (count_en !== 1'b1) begin
      errors++;
      $display("FAIL lap_tick got=%b exp=1", count_en);
    end
    checks++;
    if (display_number !== 16'h0123) begin
      errors++;
      $display("FAIL lap_hold1 got=%h exp=0123", display_number);
    end
    step(1);
    tick = 1'b0;
    live_number = 16'h0125;
    #1;
    checks++;
    if (display_number !== 16'h0123) begin
      errors++;
      $display("FAIL lap_hold2 got=%h exp=0123", display_number);
    end
    press_lap();
    checks++;
    if (lap_active !== 1'b0 || display_number !== 16'h0125) begin
      errors++;
      $display("FAIL lap_exit lap=%b disp=%h exp 0/0125",
               lap_active, display_number);
    end
    live_number = 16'h0126;
    #1;
    checks++;
    if (display_number !== 16'h0126) begin
      errors++;
      $display("FAIL lap_follow got=%h exp=0126", display_number);
    end
  endtask

  task automatic test_pause_clear();
    press_ss();
    checks++;
    if (running !== 1'b0 || dut.state_q !== ST_PAUSE) begin
      errors++;
      $display("FAIL pause_enter run=%b st=%0d exp 0/3",
               running, dut.state_q);
    end
    tick = 1'b1;
    #1;
    checks++;
    if (count_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_tick got=%b exp=0", count_en);
    end
    step(1);
    tick = 1'b0;
    btn_lap_reset = 1'b1;
    step(3);
    checks++;
    if (count_clr !== 1'b0) begin
      errors++;
      $display("FAIL clr_early got=%b exp=0", count_clr);
    end
    step(1);
    checks++;
    if (count_clr !== 1'b1 || dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL clr_pulse clr=%b st=%0d exp 1/0",
               count_clr, dut.state_q);
    end
    checks++;
    if (dut.lap_q !== 16'h0000) begin
      errors++;
      $display("FAIL clr_lapreg got=%h exp=0000", dut.lap_q);
    end
    step(1);
    checks++;
    if (count_clr !== 1'b0) begin
      errors++;
      $display("FAIL clr_width got=%b exp=0", count_clr);
    end
    btn_lap_reset = 1'b0;
    step(4);
  endtask

  task automatic test_both();
    press_ss();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL both_setup got=%b exp=1", running);
    end
    live_number = 16'h0777;
    btn_start_stop = 1'b1;
    btn_lap_reset = 1'b1;
    step(4);
    btn_start_stop = 1'b0;
    btn_lap_reset = 1'b0;
    checks++;
    if (dut.state_q !== ST_PAUSE || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL both_state st=%0d lap=%b exp 3/0",
               dut.state_q, lap_active);
    end
    checks++;
    if (dut.lap_q !== 16'h0000) begin
      errors++;
      $display("FAIL both_nocap got=%h exp=0000", dut.lap_q);
    end
    step(4);
  endtask

  task automatic test_reset_mid();
    press_ss();
    live_number = 16'h0042;
    btn_lap_reset = 1'b1;
    step(4);
    checks++;
    if (lap_active !== 1'b1) begin
      errors++;
      $display("FAIL mid_lap got=%b exp=1", lap_active);
    end
    live_number = 16'h0050;
    #1;
    checks++;
    if (display_number !== 16'h0042) begin
      errors++;
      $display("FAIL mid_hold got=%h exp=0042", display_number);
    end
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    checks++;
    if (running !== 1'b0 || lap_active !== 1'b0 ||
        count_clr !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst run=%b lap=%b clr=%b exp 0/0/0",
               running, lap_active, count_clr);
    end
    checks++;
    if (display_number !== 16'h0050) begin
      errors++;
      $display("FAIL mid_disp got=%h exp=0050", display_number);
    end
    step(3);
    btn_lap_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if (count_clr !== 1'b0 || dut.state_q !== ST_IDLE) begin
        errors++;
        $display("FAIL mid_nopress%0d clr=%b st=%0d exp 0/0",
                 i, count_clr, dut.state_q);
      end
    end
    btn_lap_reset = 1'b1;
    step(4);
    checks++;
    if (count_clr !== 1'b1 || dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_fresh clr=%b st=%0d exp 1/0",
               count_clr, dut.state_q);
    end
    btn_lap_reset = 1'b0;
    step(4);
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_clear();
    test_both();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
